fsm_seq_calc: RTL

Parametrised sequential calculator FSM, the next-generation integer calculator for this codebase. It takes an opcode and two signed operands over one shared input bus with a valid/ready handshake. It computes add, subtract, multiply, min or max at a full-precision result width. Multiply is iterative (shift-add); the result is reported with a one-cycle valid pulse plus overflow and error flags.

---
 rtl/fsm_seq_calc.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fsm_seq_calc.sv
// Sequential integer calculator: opcode/operand handshake, 1-cycle add/sub/min/max, WIDTH-cycle shift-add multiply.
// Optional accumulate opcode (101) enabled by defining FSM_SEQ_CALC_ACCUM_EN.
module fsm_seq_calc #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_in_valid,
    input  logic [WIDTH-1:0]   i_in_data,
    output logic               o_in_ready,
    output logic               o_res_valid,
    output logic [2*WIDTH-1:0] o_res_data,
    output logic               o_ovf,
    output logic               o_err,
    output logic               o_busy,
    output logic [2:0]         o_state
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2,
                           OP_MAX = 3'd3, OP_MIN = 3'd4, OP_ACC = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_OPA = 3'd1, S_OPB = 3'd2, S_EXEC = 3'd3, S_DONE = 3'd4
    } state_t;

    state_t                    r_state, w_next;
    logic [2:0]                r_op;
    logic signed [WIDTH-1:0]   r_a, r_b;
    logic signed [2*WIDTH-1:0] r_res;
    logic                      r_ovf, r_err, r_res_valid, r_neg;
    logic [2*WIDTH-1:0]        r_prod, r_mcand;
    logic [WIDTH-1:0]          r_mplier;
    logic [CW-1:0]             r_cnt;

    logic                      w_xfer, w_legal, w_exec_last, w_ovf;
    logic [2:0]                w_in_op;
    logic signed [2*WIDTH-1:0] w_sa, w_sb, w_result;
    logic [2*WIDTH-1:0]        w_mag_prod;

    function automatic logic [WIDTH-1:0] f_abs(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign o_in_ready  = (r_state == S_IDLE) || (r_state == S_OPA) || (r_state == S_OPB);
    assign o_busy      = (r_state == S_EXEC) || (r_state == S_DONE);
    assign o_state     = r_state;
    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res;
    assign o_ovf       = r_ovf;
    assign o_err       = r_err;

    assign w_xfer  = i_in_valid && o_in_ready;
    assign w_in_op = i_in_data[2:0];
`ifdef FSM_SEQ_CALC_ACCUM_EN
    assign w_legal = (w_in_op <= OP_MIN) || (w_in_op == OP_ACC);
`else
    assign w_legal = (w_in_op <= OP_MIN);
`endif

    // Only MUL iterates; every other opcode leaves EXEC after one cycle.
    assign w_exec_last = (r_op != OP_MUL) || (r_cnt == CW'(WIDTH-1));

    assign w_sa       = {{WIDTH{r_a[WIDTH-1]}}, r_a};
    assign w_sb       = {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_mag_prod = r_prod + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_result = '0;
        case (r_op)
            OP_ADD, OP_ACC: w_result = w_sa + w_sb;
            OP_SUB:         w_result = w_sa - w_sb;
            OP_MUL:         w_result = $signed(r_neg ? -w_mag_prod : w_mag_prod);
            OP_MAX:         w_result = (r_a >= r_b) ? w_sa : w_sb;
            OP_MIN:         w_result = (r_a <= r_b) ? w_sa : w_sb;
            default:        w_result = '0;
        endcase
        w_ovf = (w_result != {{WIDTH{w_result[WIDTH-1]}}, w_result[WIDTH-1:0]});
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_xfer && w_legal) w_next = (w_in_op == OP_ACC) ? S_OPB : S_OPA;
            S_OPA:  if (w_xfer) w_next = S_OPB;
            S_OPB:  if (w_xfer) w_next = S_EXEC;
            S_EXEC: if (w_exec_last) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_res_valid <= 1'b0;
            r_neg       <= 1'b0;
            r_prod      <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (w_xfer) begin
                    r_op <= w_in_op;
                    if (w_legal) begin
                        r_err <= 1'b0;
                        // ACC skips OPA, so A is preloaded from the previous result here.
                        r_a   <= r_res[WIDTH-1:0];
                    end else begin
                        r_err       <= 1'b1;
                        r_res_valid <= 1'b1;
                    end
                end
                S_OPA: if (w_xfer) r_a <= i_in_data;
                S_OPB: if (w_xfer) begin
                    r_b      <= i_in_data;
                    r_neg    <= r_a[WIDTH-1] ^ i_in_data[WIDTH-1];
                    r_mcand  <= {{WIDTH{1'b0}}, f_abs(r_a)};
                    r_mplier <= f_abs(i_in_data);
                    r_prod   <= '0;
                    r_cnt    <= '0;
                end
                S_EXEC: if (w_exec_last) begin
                    r_res       <= w_result;
                    r_ovf       <= w_ovf;
                    r_res_valid <= 1'b1;
                end else begin
                    r_prod   <= w_mag_prod;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
